// File: rtl/mpmc11_pkg.sv
// Shared types and defaults for the mpmc11 sequencer and its timeout handler.
package mpmc11_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    REF  = 3'd5
  } mpmc11_state_t;

  typedef enum logic [1:0] {
    TOH_MON   = 2'd0,
    TOH_ABORT = 2'd1,
    TOH_COOL  = 2'd2,
    TOH_FATAL = 2'd3
  } mpmc11_to_state_t;

  localparam logic [15:0] MPMC11_TO_LIMIT = 16'd500;

endpackage

// File: rtl/mpmc11_to_handler.sv
// Timeout watchdog for the mpmc11 sequencer: requests an abort to IDLE on a
// hang, records diagnostics and escalates to a sticky fatal flag.
module mpmc11_to_handler
  import mpmc11_pkg::*;
#(
  parameter logic [15:0] TO_LIMIT  = MPMC11_TO_LIMIT,
  parameter int          ERR_W     = 8,
  parameter int          COOLDOWN  = 8,
  parameter int          MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  mpmc11_state_t        state,
  input  logic [15:0]          to_cnt,
  input  logic [3:0]           ch,
  input  logic                 clr_i,
  output logic                 abort_o,
  output logic                 to_err,
  output mpmc11_state_t        to_state,
  output logic [3:0]           to_ch,
  output logic [ERR_W-1:0]     to_count,
  output logic                 fatal_o,
  output mpmc11_to_state_t     dbg_fsm_o
);

  localparam int          RW       = $clog2(MAX_RETRY + 1);
  localparam int          CW       = $clog2(COOLDOWN + 2);
  localparam logic [15:0] ABT_LAST = TO_LIMIT - 16'd1;

  mpmc11_to_state_t   fsm_q;
  logic               abort_q, to_err_q, fatal_q, prev_idle_q;
  mpmc11_state_t      to_state_q;
  logic [3:0]         to_ch_q;
  logic [ERR_W-1:0]   to_count_q;
  logic [RW-1:0]      retry_q;
  logic [CW-1:0]      cool_cnt_q;
  logic [15:0]        abt_cnt_q;

  logic               hit;
  logic [ERR_W-1:0]   cnt_base_d, to_count_d;
  logic [RW-1:0]      retry_d;

  // A clear in the same cycle as a hit restarts the counts from zero
  // before the hit is applied, so the hit is never lost.
  always_comb begin
    hit        = (state != IDLE) && (to_cnt >= TO_LIMIT);
    cnt_base_d = clr_i ? '0 : to_count_q;
    to_count_d = (&cnt_base_d) ? cnt_base_d : cnt_base_d + 1'b1;
    retry_d    = (clr_i ? '0 : retry_q) + 1'b1;
  end

  // abort_o is a level request; the sequencer acknowledges it by reaching
  // IDLE, which the handler observes on the state input (no separate ready).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= TOH_MON;
      abort_q     <= 1'b0;
      to_err_q    <= 1'b0;
      fatal_q     <= 1'b0;
      prev_idle_q <= 1'b1;
      to_state_q  <= IDLE;
      to_ch_q     <= 4'd0;
      to_count_q  <= '0;
      retry_q     <= '0;
      cool_cnt_q  <= '0;
      abt_cnt_q   <= 16'd0;
    end else begin
      prev_idle_q <= (state == IDLE);
      if (clr_i) begin
        to_err_q   <= 1'b0;
        to_count_q <= '0;
        fatal_q    <= 1'b0;
        retry_q    <= '0;
      end
      case (fsm_q)
        TOH_MON: begin
          if (hit) begin
            to_state_q <= state;
            to_ch_q    <= ch;
            to_count_q <= to_count_d;
            to_err_q   <= 1'b1;
            retry_q    <= retry_d;
            abort_q    <= 1'b1;
            abt_cnt_q  <= 16'd0;
            if (retry_d == RW'(MAX_RETRY)) begin
              fatal_q <= 1'b1;
              fsm_q   <= TOH_FATAL;
            end else begin
              fsm_q <= TOH_ABORT;
            end
          end else if (!prev_idle_q && state == IDLE) begin
            retry_q <= '0;
          end
        end
        TOH_ABORT: begin
          if (state == IDLE) begin
            abort_q    <= 1'b0;
            cool_cnt_q <= CW'(COOLDOWN);
            fsm_q      <= TOH_COOL;
          end else if (abt_cnt_q == ABT_LAST) begin
            fatal_q <= 1'b1;
            fsm_q   <= TOH_FATAL;
          end else begin
            abt_cnt_q <= abt_cnt_q + 16'd1;
          end
        end
        TOH_COOL: begin
          cool_cnt_q <= (cool_cnt_q == '0) ? '0 : cool_cnt_q - 1'b1;
          if (cool_cnt_q <= CW'(1)) fsm_q <= TOH_MON;
        end
        TOH_FATAL: begin
          if (clr_i) begin
            abort_q <= 1'b0;
            fsm_q   <= TOH_MON;
          end
        end
        default: fsm_q <= TOH_MON;
      endcase
    end
  end

  assign abort_o   = abort_q;
  assign to_err    = to_err_q;
  assign to_state  = to_state_q;
  assign to_ch     = to_ch_q;
  assign to_count  = to_count_q;
  assign fatal_o   = fatal_q;
  assign dbg_fsm_o = fsm_q;

endmodule

// File: tb/tb_mpmc11_to_handler.sv
// Directed bench for mpmc11_to_handler with hand-computed expectations.
module tb_mpmc11_to_handler;
  import mpmc11_pkg::*;

  localparam logic [15:0] TO_LIMIT = 16'd500;
  localparam int          COOLDOWN = 8;

  logic             clk = 1'b0;
  logic             rst;
  mpmc11_state_t    state;
  logic [15:0]      to_cnt;
  logic [3:0]       ch;
  logic             clr_i;
  logic             abort_o, to_err, fatal_o;
  mpmc11_state_t    to_state;
  logic [3:0]       to_ch;
  logic [7:0]       to_count;
  mpmc11_to_state_t dbg_fsm_o;

  int n_checks = 0;
  int n_pass   = 0;

  mpmc11_to_handler dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .to_cnt    (to_cnt),
    .ch        (ch),
    .clr_i     (clr_i),
    .abort_o   (abort_o),
    .to_err    (to_err),
    .to_state  (to_state),
    .to_ch     (to_ch),
    .to_count  (to_count),
    .fatal_o   (fatal_o),
    .dbg_fsm_o (dbg_fsm_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_hit(input mpmc11_state_t st, input logic [3:0] c);
    state = st; ch = c; to_cnt = TO_LIMIT;
    step();
    to_cnt = 16'd0;
  endtask

  task automatic finish_abort();
    state = IDLE; to_cnt = 16'd0;
    step();
    repeat (COOLDOWN) step();
  endtask

  task automatic clean_run();
    state = RD; to_cnt = 16'd1;
    step();
    state = IDLE; to_cnt = 16'd0;
    step();
  endtask

  initial begin
    rst = 1'b1; state = IDLE; to_cnt = 16'd0; ch = 4'd0; clr_i = 1'b0;
    repeat (3) step();
    check("rst_abort", abort_o, 0);
    check("rst_fsm", dbg_fsm_o, TOH_MON);
    rst = 1'b0;
    step();
    check("rst_count", to_count, 0);
    check("rst_err", to_err, 0);
    check("rst_fatal", fatal_o, 0);
    check("rst_to_state", to_state, IDLE);

    // IDLE never times out
    state = IDLE; to_cnt = 16'd600;
    repeat (3) step();
    check("idle_abort", abort_o, 0);
    check("idle_count", to_count, 0);

    // just below limit, then at limit
    state = RD; ch = 4'd5; to_cnt = 16'd499;
    step();
    check("below_abort", abort_o, 0);
    fire_hit(RD, 4'd5);
    check("hit_abort", abort_o, 1);
    check("hit_err", to_err, 1);
    check("hit_count", to_count, 1);
    check("hit_ch", to_ch, 5);
    check("hit_state", to_state, RD);
    check("hit_fsm", dbg_fsm_o, TOH_ABORT);

    // sequencer reaches IDLE after 3 cycles; hit in COOL ignored
    step(); step();
    check("abort_hold", abort_o, 1);
    state = IDLE;
    step();
    check("cool_abort", abort_o, 0);
    check("cool_fsm", dbg_fsm_o, TOH_COOL);
    state = WR; to_cnt = 16'd600;
    repeat (3) step();
    check("cool_ign_abort", abort_o, 0);
    check("cool_ign_count", to_count, 1);
    state = IDLE; to_cnt = 16'd0;
    repeat (4) step();
    check("cool_still", dbg_fsm_o, TOH_COOL);
    step();
    check("cool_done", dbg_fsm_o, TOH_MON);

    // retry reaches MAX_RETRY on third consecutive timeout
    clean_run();
    fire_hit(ACT, 4'd1);
    check("rt1_fsm", dbg_fsm_o, TOH_ABORT);
    finish_abort();
    fire_hit(PRE, 4'd2);
    check("rt2_fsm", dbg_fsm_o, TOH_ABORT);
    check("rt2_fatal", fatal_o, 0);
    finish_abort();
    fire_hit(REF, 4'd3);
    check("rt3_fatal", fatal_o, 1);
    check("rt3_fsm", dbg_fsm_o, TOH_FATAL);
    check("rt3_count", to_count, 4);
    state = IDLE;
    repeat (3) step();
    check("fatal_abort", abort_o, 1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_fatal", fatal_o, 0);
    check("clr_fsm", dbg_fsm_o, TOH_MON);
    check("clr_abort", abort_o, 0);
    check("clr_err", to_err, 0);
    check("clr_count", to_count, 0);
    check("clr_ch_kept", to_ch, 3);

    // clear coincident with hit
    fire_hit(RD, 4'd6);
    finish_abort();
    check("pre_coinc_count", to_count, 1);
    clr_i = 1'b1;
    fire_hit(WR, 4'd7);
    clr_i = 1'b0;
    check("coinc_err", to_err, 1);
    check("coinc_count", to_count, 1);
    // clear during ABORT does not cancel it
    state = WR;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_abt_fsm", dbg_fsm_o, TOH_ABORT);
    check("clr_abt_abort", abort_o, 1);
    check("clr_abt_count", to_count, 0);
    finish_abort();

    // abort ignored for TO_LIMIT cycles escalates to fatal
    fire_hit(RD, 4'd8);
    state = RD;
    repeat (499) step();
    check("ign_pre_fsm", dbg_fsm_o, TOH_ABORT);
    check("ign_pre_fatal", fatal_o, 0);
    step();
    check("ign_fatal", fatal_o, 1);
    check("ign_fsm", dbg_fsm_o, TOH_FATAL);
    clr_i = 1'b1; state = IDLE;
    step();
    clr_i = 1'b0;
    step();

    // saturation of to_count
    for (int i = 0; i < 254; i++) begin
      fire_hit(RD, 4'd9);
      finish_abort();
      clean_run();
    end
    check("sat_254", to_count, 8'd254);
    fire_hit(RD, 4'd9);
    finish_abort();
    clean_run();
    check("sat_255", to_count, 8'hFF);
    fire_hit(WR, 4'd10);
    check("sat_hold", to_count, 8'hFF);
    check("sat_abort", abort_o, 1);

    // asynchronous reset mid-ABORT
    #2;
    rst = 1'b1;
    #1;
    check("arst_abort", abort_o, 0);
    check("arst_count", to_count, 0);
    check("arst_err", to_err, 0);
    check("arst_ch", to_ch, 0);
    check("arst_fsm", dbg_fsm_o, TOH_MON);
    step();
    rst = 1'b0;
    step();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
